fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage between the instruction BRAM and the decoder. Owns the fetch PC, issues word addresses to the synchronous-read instruction BRAM, buffers returned words with their PCs in a small prefetch FIFO, and presents them to the control FSM through a valid/ready handshake. Taken branches and jumps flush the buffer and restart fetch through a single-cycle redirect.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0, first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  fetch enable; gates new issues only.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address (word address).
- imem_addr  out  32  instruction BRAM address; equals fetch_pc.
- imem_rdata  in  32  BRAM read data; valid the cycle after the address.
- instr_valid  out  1  FIFO head holds an instruction.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of the head instruction.
- instr_ready  in  1  consumer accepts the head this cycle.

## Operation
- State: fetch_pc (32), inflight flag with inflight_pc (32), FIFO of {pc, word} with rd_ptr and wr_ptr (log2(DEPTH)+1 bits each), and count.
- Issue: when en=1 and count+inflight < DEPTH, set inflight<=1, inflight_pc<=fetch_pc, and fetch_pc<=fetch_pc+1. Word addressing: the increment is 1, and wrap from 32'hFFFFFFFF to 0 is silent.
- Capture: when inflight=1 in a cycle, write {inflight_pc, imem_rdata} at wr_ptr. Inflight is cleared unless a new issue occurs in the same cycle.
- Pop: when instr_valid && instr_ready, advance rd_ptr. Push and pop can occur in the same cycle; count is then unchanged.
- The credit rule counts the in-flight word, so the FIFO never overflows. Pop does not return credit in the same cycle.
- instr_valid = (count != 0). instr and instr_pc are read combinationally from the head entry.
- Redirect has priority over every other event in that cycle:
  - The FIFO is emptied.
  - The inflight word is dropped, so no capture happens.
  - fetch_pc<=redirect_pc.
  - No issue happens in the redirect cycle.
  - A pop in the same cycle is ignored by the FIFO. The consumer must not rely on a pop during redirect.
- en=0 stops issuing only. An in-flight word is still captured, and the FIFO still drains.

## Timing
- Reset values while rst=0:
  - fetch_pc=RESET_PC, so imem_addr=RESET_PC.
  - inflight=0, count=0, pointers=0.
  - instr_valid=0. instr and instr_pc are don't-care but must not be X-propagating into valid.
- Issue-to-valid latency is 2 cycles. Address issued in cycle c, imem_rdata sampled at the end of c+1, instr_valid=1 in c+2.
- Redirect asserted in cycle r: imem_addr=redirect_pc in r+1, which is the first issue. That instruction is valid in r+3.
- Sustained throughput is 1 instruction/cycle with instr_ready held high and DEPTH≥4.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first issue occurs in the first cycle after deassertion in which en=1.

## Configuration
- FETCH_STATS_EN defined:
  - Adds outputs stat_fetched (32 bits), counting accepted pops, and stat_flushes (32 bits), counting redirect cycles.
  - Both counters are cleared by rst and wrap silently.
- FETCH_STATS_EN undefined: the ports and counters are absent, and fetch behaviour is otherwise identical.

## Structure
- A shared package holds:
  - the instruction word width constant (32);
  - the fetch entry typedef {pc, word};
  - the default DEPTH and RESET_PC constants.
- Sub-module fetch_fifo: a parameterised synchronous FIFO with flush, push, pop, count, and a combinational head. The fetch_unit top holds the PC, the inflight logic and the redirect priority.

## Test plan
- Reset then stream: rst released, en=1, instr_ready=1, BRAM preloaded word[i]=i+32'hA000 → instr_pc 0,1,2,… with instr A000,A001,…; first valid 2 cycles after first issue, then one per cycle.
- Backpressure: instr_ready=0 for 10 cycles → count saturates at DEPTH and issues stop with imem_addr holding at 4. Release → PCs 0..N in order with no loss or duplication.
- Redirect while full: FIFO full, redirect=1 with redirect_pc=32'h40 → instr_valid=0 in the next cycle, imem_addr=32'h40, and first instr_pc=32'h40 three cycles after the redirect.
- Redirect with in-flight word and simultaneous pop: the stale word is never presented, and the next presented instr_pc equals redirect_pc.
- en toggling and reset mid-stream: en=0 freezes imem_addr while already-buffered words still drain. rst pulsed mid-stream → instr_valid=0 at once, and fetch restarts at RESET_PC.
- With FETCH_STATS_EN: 8 pops and 2 redirects → stat_fetched=8 and stat_flushes=2. Without the macro the build has no stat ports.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned FETCH_DEPTH_DEFAULT = 4;
    localparam logic [XLEN-1:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction BRAM port, decoder handshake and redirect request.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            en;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        input  en, redirect, redirect_pc, imem_rdata, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output en, redirect, redirect_pc, imem_rdata, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: prefetch buffer of {pc, word} entries with flush and a combinational head.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [CW-1:0] rd_ptr_r;
    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    // Storage, pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r    <= '{default: '0};
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + CW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + CW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, one-word-in-flight BRAM issue, prefetch buffer and redirect.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushes counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushes
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] inflight_pc_r;

    logic [CW-1:0]   count_s;
    logic [CW:0]     credit_used_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;
    logic            valid_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;

    assign valid_s = (count_s != '0);

    // Event decode: redirect suppresses issue, capture and pop in the same cycle.
    always_comb begin
        credit_used_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
        push_entry_s  = '{pc: inflight_pc_r, word: bus.imem_rdata};
        issue_s       = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        if (bus.redirect) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end else begin
            // The in-flight word holds a slot, so the buffer can never overflow.
            issue_s = bus.en && (credit_used_s < (CW + 1)'(DEPTH));
            push_s  = inflight_r;
            pop_s   = valid_s && bus.instr_ready;
        end
    end

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            inflight_r <= 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + 32'd1;
                inflight_pc_r <= fetch_pc_r;
            end
            inflight_r <= issue_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign bus.imem_addr   = fetch_pc_r;
    assign bus.instr_valid = valid_s;
    assign bus.instr       = head_s.word;
    assign bus.instr_pc    = head_s.pc;

`ifdef FETCH_STATS_EN
    // Accepted-pop and redirect-cycle counters, wrapping silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched <= 32'd0;
            stat_flushes <= 32'd0;
        end else begin
            if (pop_s) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (bus.redirect) begin
                stat_flushes <= stat_flushes + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a BRAM model returning addr+32'hA000.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_unit_if bus();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushes;
    logic [31:0] model_fetched;
    logic [31:0] model_flushes;
`endif

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushes (stat_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory: word[a] = a + 32'hA000.
    always @(posedge clk) bus.imem_rdata <= bus.imem_addr + 32'hA000;

`ifdef FETCH_STATS_EN
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_fetched <= 32'd0;
            model_flushes <= 32'd0;
        end else begin
            if (bus.redirect) model_flushes <= model_flushes + 32'd1;
            else if (bus.instr_valid && bus.instr_ready) model_fetched <= model_fetched + 32'd1;
        end
    end
`endif

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic v, input logic [31:0] a, input logic [31:0] p);
        vec_t r;
        r.en = en; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.exp_valid = v; r.exp_addr = a; r.exp_pc = p;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] p);
        logic [31:0] w;
        check({tag, " valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
        check({tag, " addr"}, bus.imem_addr, a);
        if (v) begin
            w = p + 32'hA000;
            check({tag, " pc"}, bus.instr_pc, p);
            check({tag, " instr"}, bus.instr, w);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.en          = en;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Stream, backpressure, en gap, redirect while full, redirect with in-flight word and pop.
        for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 1'b0, 32'h0, k >= 2, 32'(k), 32'(k - 2));
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd8, 32'd6);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd9, 32'd6);
        for (int k = 10; k < 18; k++) add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd10, 32'd6);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd10, 32'd6);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd10, 32'd7);
        for (int k = 20; k < 23; k++) add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'(k - 9), 32'(k - 12));
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd14, 32'd11);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd14, 32'd12);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd14, 32'd13);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd14, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd15, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd16, 32'd14);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd17, 32'd14);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd18, 32'd14);
        add(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'd18, 32'd14);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40, 32'h0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h41, 32'h0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h42, 32'h40);
        add(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h43, 32'h41);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 32'h0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h81, 32'h0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h82, 32'h80);

        repeat (2) @(negedge clk);
        check_out("in reset", 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            check_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_addr, vecs[i].exp_pc);
            drive(vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
        end

        // Address wrap at the top of the word space.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        check_out("wrap0", 1'b0, 32'hFFFF_FFFF, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_out("wrap1", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_out("wrap2", 1'b1, 32'h1, 32'hFFFF_FFFF);
        @(negedge clk);
        check_out("wrap3", 1'b1, 32'h2, 32'h0);

        // Asynchronous reset in the middle of a cycle, then restart from RESET_PC.
        #2 rst = 1'b0;
        #1 check_out("async rst", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_out("held rst", 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_out("restart0", 1'b0, 32'h1, 32'h0);
        @(negedge clk);
        check_out("restart1", 1'b1, 32'h2, 32'h0);
        @(negedge clk);
        check_out("restart2", 1'b1, 32'h3, 32'h1);

`ifdef FETCH_STATS_EN
        // Two redirects and a stretch of pops after the mid-stream reset.
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h300);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        check("stat_fetched", stat_fetched, model_fetched);
        check("stat_flushes", stat_flushes, model_flushes);
        check("stat_flushes two", stat_flushes, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
